core_clk_ctrl: RTL and testbench
================================

// Module: core_clk_ctrl
// PURPOSE
//  Run-control and rate generator for the pipelined core. Sits on the base clock
//  (25 MHz). Produces a one-cycle clock-enable o_clk_en at a runtime-selectable rate
//  of base/2^sel. Modes: free-run, halt, single-step, with halt-on-breakpoint.
//  Replaces a fixed divided clock with an enable so the core stays on the base clock.
// PARAMETERS
//  MAX_SEL  24  largest accepted divide exponent; prescaler width = MAX_SEL bits
//  SEL_W    5   width of i_div_sel; must satisfy 2^SEL_W > MAX_SEL
// PORTS
//  i_clk        in   1      base clock; single clock domain
//  i_rst        in   1      synchronous reset, active-high
//  i_div_sel    in   SEL_W  divide exponent; enable period = 2^sel cycles; sel > MAX_SEL clamps to MAX_SEL
//  i_run_req    in   1      pulse: enter RUN
//  i_halt_req   in   1      pulse: enter HALT
//  i_step_req   in   1      pulse: from HALT, issue exactly one enable
//  i_bp_hit     in   1      core breakpoint; sampled only when o_clk_en=1 in RUN
//  o_clk_en     out  1      registered one-cycle enable to the core
//  o_halted     out  1      1 when FSM in HALT
// BEHAVIOUR
//  Reset: the FSM goes to HALT, the prescaler to 0, and sel_q to 0. o_clk_en=0, o_halted=1.
//  sel_q: i_div_sel is registered every cycle. If the new value differs from sel_q, the prescaler
//    clears to 0 that cycle. The first tick then follows 2^sel cycles later. No tick on the change cycle.
//  Prescaler: MAX_SEL-bit counter. It increments only in RUN or STEP and holds in HALT. It wraps modulo 2^MAX_SEL.
//    tick = ((cnt & mask) == mask), mask = (1<<sel_q)-1. With sel_q=0, tick is true every cycle.
//  o_clk_en: o_clk_en(t+1) = tick(t) & (state(t)==RUN || state(t)==STEP). Latency is 1 cycle.
//  FSM states: HALT, RUN, STEP.
//    HALT: halt_req has priority. Else run_req -> RUN (wins over step_req). Else step_req -> STEP.
//    RUN:  halt_req -> HALT. Else o_clk_en & i_bp_hit -> HALT. run_req and step_req are ignored.
//    STEP: halt_req before the tick -> HALT, and no enable is issued.
//          On tick -> HALT; the single o_clk_en follows in the next cycle.
//          All other requests are ignored.
//  Transition into HALT stops further ticks. An o_clk_en already registered from the previous cycle still completes.
//  A step takes 2^sel_q - (cnt & mask) cycles to its tick. Worst case is 2^sel_q cycles.
//  Reset mid-run or mid-step aborts immediately. o_clk_en=0 in the cycle after reset is sampled.
//  In HALT, o_halted=1 combinationally from the state register. No glitch on o_clk_en.
// CONFIGURATION
//  CLK_CTRL_CYCLE_COUNT_EN defined:
//    Adds output o_cycle_cnt [31:0]: the count of asserted o_clk_en. Clears on reset, wraps at 2^32.
//    Updates in the same cycle as o_clk_en. The count includes that cycle's pulse in the next value.
//  Undefined: port and counter absent. All other behaviour is identical.
// STRUCTURE
//  Package clk_ctrl_pkg:
//    typedef enum logic [1:0] {CC_HALT, CC_RUN, CC_STEP} cc_state_e;
//    localparams CC_MAX_SEL_DEF=24, CC_SEL_W_DEF=5.
//  Sub-module clk_tick_prescaler contains: counter, sel_q register, change-clear, mask and tick.
//    Its inputs are i_clk, i_rst, i_en, i_sel. Its output is o_tick.
//  The top level holds the FSM, the o_clk_en register and the optional cycle counter.
// TESTING
//  1. Reset, then i_run_req with sel=0 -> o_clk_en=1 every cycle starting 2 cycles after the request. o_halted goes 0.
//  2. RUN with sel=3 -> o_clk_en pulses exactly every 8 cycles. Change sel to 1 -> no pulse for 2 cycles, then one every 2.
//  3. HALT with sel=2, then step_req -> exactly one o_clk_en within 4 cycles, back in HALT.
//     Ten steps -> 10 pulses, and o_cycle_cnt=10 when the macro is defined.
//  4. Same-cycle run_req, halt_req and step_req in HALT -> stays HALT.
//     run_req with step_req -> RUN.
//  5. RUN, sel=0, i_bp_hit held 1 -> one o_clk_en, then HALT. o_halted=1 and no further pulses.
//  6. i_rst asserted for 1 cycle mid-STEP with sel=4 -> no o_clk_en after reset. o_halted=1, prescaler restarts from 0.
//     Also: sel=31 clamps to 24 (spot-check mask only).

Source files
------------

// File: rtl/clk_ctrl_pkg.sv
// Shared types and defaults for the core run-control / rate generator.
// Optional feature macro: CLK_CTRL_CYCLE_COUNT_EN (adds o_cycle_cnt on core_clk_ctrl).
package clk_ctrl_pkg;

  localparam int CC_MAX_SEL_DEF = 24;
  localparam int CC_SEL_W_DEF   = 5;

  typedef enum logic [1:0] {
    CC_HALT,
    CC_RUN,
    CC_STEP
  } cc_state_e;

endpackage

// File: rtl/clk_tick_prescaler.sv
// Power-of-two prescaler: registers the (clamped) divide exponent, clears the
// counter whenever the exponent changes, and flags a tick when the low sel_q
// counter bits are all ones. The counter only advances while i_en is high.
module clk_tick_prescaler
  import clk_ctrl_pkg::*;
#(
  parameter int MAX_SEL = CC_MAX_SEL_DEF,
  parameter int SEL_W   = CC_SEL_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [SEL_W-1:0] i_sel,
  output logic             o_tick
);

  logic [SEL_W-1:0]   sel_clamp;
  logic [SEL_W-1:0]   sel_d, sel_q;
  logic [MAX_SEL-1:0] cnt_d, cnt_q;
  logic [MAX_SEL-1:0] mask;
  logic               sel_change;

  // Clamp the exponent, build the low-bit mask, and compute next counter state.
  always_comb begin
    sel_clamp  = (i_sel > SEL_W'(MAX_SEL)) ? SEL_W'(MAX_SEL) : i_sel;
    sel_change = (sel_clamp != sel_q);
    sel_d      = sel_clamp;
    mask       = '0;
    for (int i = 0; i < MAX_SEL; i++) begin
      mask[i] = (i < int'(sel_q));
    end
    cnt_d = cnt_q;
    if (sel_change) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + MAX_SEL'(1);
    end
    // A rate change restarts the period, so the change cycle never ticks.
    o_tick = ~sel_change & ((cnt_q & mask) == mask);
  end

  // Exponent and counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sel_q <= '0;
      cnt_q <= '0;
    end else begin
      sel_q <= sel_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/core_clk_ctrl.sv
// Run-control and rate generator for the pipelined core. Emits a registered
// one-cycle clock enable at base/2^sel in RUN, a single enable per STEP, and
// nothing in HALT. Breakpoints are honoured only on cycles the core advanced.
// Optional feature macro: CLK_CTRL_CYCLE_COUNT_EN adds o_cycle_cnt, the count
// of issued enables.
module core_clk_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int MAX_SEL = CC_MAX_SEL_DEF,
  parameter int SEL_W   = CC_SEL_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [SEL_W-1:0] i_div_sel,
  input  logic             i_run_req,
  input  logic             i_halt_req,
  input  logic             i_step_req,
  input  logic             i_bp_hit,
  output logic             o_clk_en,
  output logic             o_halted
`ifdef CLK_CTRL_CYCLE_COUNT_EN
  ,
  output logic [31:0]      o_cycle_cnt
`endif
);

  cc_state_e state_d, state_q;
  logic      clk_en_d, clk_en_q;
  logic      tick;
  logic      presc_en;

  assign presc_en = (state_q == CC_RUN) || (state_q == CC_STEP);

  clk_tick_prescaler #(
    .MAX_SEL (MAX_SEL),
    .SEL_W   (SEL_W)
  ) u_presc (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (presc_en),
    .i_sel  (i_div_sel),
    .o_tick (tick)
  );

  // Next state and next enable. Any transition into HALT suppresses the tick of
  // that cycle, except the STEP tick which is the one enable the step owes.
  always_comb begin
    state_d  = state_q;
    clk_en_d = 1'b0;
    case (state_q)
      CC_HALT: begin
        if (i_halt_req) begin
          state_d = CC_HALT;
        end else if (i_run_req) begin
          state_d = CC_RUN;
        end else if (i_step_req) begin
          state_d = CC_STEP;
        end
      end
      CC_RUN: begin
        if (i_halt_req) begin
          state_d = CC_HALT;
        end else if (clk_en_q && i_bp_hit) begin
          state_d = CC_HALT;
        end else begin
          clk_en_d = tick;
        end
      end
      CC_STEP: begin
        if (i_halt_req) begin
          state_d = CC_HALT;
        end else if (tick) begin
          state_d  = CC_HALT;
          clk_en_d = 1'b1;
        end
      end
      default: state_d = CC_HALT;
    endcase
  end

  // State and enable registers; reset parks the core in HALT with no enable.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= CC_HALT;
      clk_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      clk_en_q <= clk_en_d;
    end
  end

  assign o_clk_en = clk_en_q;
  assign o_halted = (state_q == CC_HALT);

`ifdef CLK_CTRL_CYCLE_COUNT_EN
  logic [31:0] cyc_cnt_d, cyc_cnt_q;

  assign cyc_cnt_d = cyc_cnt_q + 32'(clk_en_q);

  // Enable counter: accumulates each pulse as it is presented to the core.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cyc_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
    end
  end

  assign o_cycle_cnt = cyc_cnt_q;
`endif

endmodule

// File: tb/tb_core_clk_ctrl.sv
// Scoreboard bench for core_clk_ctrl: a cycle model pushes expected outputs,
// a monitor pops and compares on the falling edge.
module tb_core_clk_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] div_sel = '0;
  logic       run_req = 1'b0;
  logic       halt_req = 1'b0;
  logic       step_req = 1'b0;
  logic       bp_hit = 1'b0;
  logic       clk_en;
  logic       halted;
`ifdef CLK_CTRL_CYCLE_COUNT_EN
  logic [31:0] cyc_cnt;
`endif

  always #5 clk = ~clk;

  core_clk_ctrl #(.MAX_SEL(24), .SEL_W(5)) u_dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_div_sel  (div_sel),
    .i_run_req  (run_req),
    .i_halt_req (halt_req),
    .i_step_req (step_req),
    .i_bp_hit   (bp_hit),
    .o_clk_en   (clk_en),
    .o_halted   (halted)
`ifdef CLK_CTRL_CYCLE_COUNT_EN
    ,
    .o_cycle_cnt(cyc_cnt)
`endif
  );

  typedef struct {
    bit          en;
    bit          halted;
    int unsigned cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   pulses = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", nm, act, req, $time);
    end
  endtask

  // Reference model: run mode as a small enum, rate as period = 2**sel with
  // the counter kept as a plain integer modulo 2**24.
  typedef enum {M_HALT, M_RUN, M_STEP} mstate_t;
  mstate_t     m_state = M_HALT;
  longint      m_cnt = 0;
  int          m_sel = 0;
  bit          m_en = 1'b0;
  int unsigned m_cyc = 0;
  int          s_new;
  longint      per;
  bit          chg, tk, en_n;
  mstate_t     ns;
  exp_t        e_push;

  always @(posedge clk) begin
    if (rst) begin
      m_state = M_HALT; m_cnt = 0; m_sel = 0; m_en = 1'b0; m_cyc = 0;
    end else begin
      s_new = (div_sel > 5'd24) ? 24 : int'(div_sel);
      chg   = (s_new != m_sel);
      per   = 64'd1 << m_sel;
      tk    = !chg && ((m_cnt % per) == per - 1);
      ns    = m_state;
      en_n  = 1'b0;
      case (m_state)
        M_HALT: if (!halt_req) begin
          if (run_req) ns = M_RUN;
          else if (step_req) ns = M_STEP;
        end
        M_RUN: begin
          if (halt_req) ns = M_HALT;
          else if (m_en && bp_hit) ns = M_HALT;
          else en_n = tk;
        end
        M_STEP: begin
          if (halt_req) ns = M_HALT;
          else if (tk) begin ns = M_HALT; en_n = 1'b1; end
        end
        default: ns = M_HALT;
      endcase
      m_cyc = m_cyc + (m_en ? 1 : 0);
      if (chg) m_cnt = 0;
      else if (m_state != M_HALT) m_cnt = (m_cnt + 1) % (64'd1 << 24);
      m_sel   = s_new;
      m_state = ns;
      m_en    = en_n;
    end
    e_push.en     = m_en;
    e_push.halted = (m_state == M_HALT);
    e_push.cyc    = m_cyc;
    exp_q.push_back(e_push);
  end

  // Monitor: compares the DUT against the oldest expectation each cycle.
  exp_t e_pop;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_pop = exp_q.pop_front();
      chk("sb_clk_en", 32'(clk_en), 32'(e_pop.en));
      chk("sb_halted", 32'(halted), 32'(e_pop.halted));
`ifdef CLK_CTRL_CYCLE_COUNT_EN
      chk("sb_cycle_cnt", cyc_cnt, e_pop.cyc);
`endif
      if (clk_en === 1'b1) pulses++;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse_req(input int which);
    if (which == 0) run_req = 1'b1;
    if (which == 1) halt_req = 1'b1;
    if (which == 2) step_req = 1'b1;
    wait_cyc(1);
    run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  int p0;
  int c0;
  initial begin
    wait_cyc(3);
    chk("reset_halted", 32'(halted), 32'd1);
    chk("reset_clk_en", 32'(clk_en), 32'd0);
    rst = 1'b0;

    // Free run at full rate.
    div_sel = 5'd0;
    wait_cyc(1);
    pulse_req(0);
    wait_cyc(3);
    chk("t1_running", 32'(halted), 32'd0);
    p0 = pulses;
    wait_cyc(10);
    chk("t1_pulse_count", 32'(pulses - p0), 32'd10);

    // Divide by 8, then by 2.
    div_sel = 5'd3;
    wait_cyc(20);
    p0 = pulses;
    wait_cyc(64);
    chk("t2_div8_count", 32'(pulses - p0), 32'd8);
    div_sel = 5'd1;
    wait_cyc(4);
    p0 = pulses;
    wait_cyc(32);
    chk("t2_div2_count", 32'(pulses - p0), 32'd16);
    pulse_req(1);
    wait_cyc(3);
    chk("t2_halted", 32'(halted), 32'd1);

    // Ten single steps from a fresh reset.
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    div_sel = 5'd2;
    wait_cyc(2);
    p0 = pulses;
`ifdef CLK_CTRL_CYCLE_COUNT_EN
    c0 = int'(cyc_cnt);
    chk("t3_cnt_start", cyc_cnt, 32'd0);
`else
    c0 = 0;
`endif
    for (int i = 0; i < 10; i++) begin
      pulse_req(2);
      wait_cyc(7);
      chk("t3_step_halted", 32'(halted), 32'd1);
    end
    chk("t3_step_pulses", 32'(pulses - p0), 32'd10);
`ifdef CLK_CTRL_CYCLE_COUNT_EN
    chk("t3_cycle_cnt", cyc_cnt - 32'(c0), 32'd10);
`endif

    // Simultaneous requests in HALT.
    run_req = 1'b1; halt_req = 1'b1; step_req = 1'b1;
    wait_cyc(1);
    run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
    wait_cyc(3);
    chk("t4_all_reqs_halt", 32'(halted), 32'd1);
    run_req = 1'b1; step_req = 1'b1;
    wait_cyc(1);
    run_req = 1'b0; step_req = 1'b0;
    wait_cyc(2);
    chk("t4_run_wins", 32'(halted), 32'd0);
    pulse_req(1);
    wait_cyc(3);

    // Breakpoint held high at full rate.
    div_sel = 5'd0;
    wait_cyc(2);
    bp_hit = 1'b1;
    p0 = pulses;
    pulse_req(0);
    wait_cyc(10);
    chk("t5_bp_one_pulse", 32'(pulses - p0), 32'd1);
    chk("t5_bp_halted", 32'(halted), 32'd1);
    bp_hit = 1'b0;

    // Reset in the middle of a slow step.
    div_sel = 5'd4;
    wait_cyc(2);
    pulse_req(2);
    wait_cyc(3);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    p0 = pulses;
    wait_cyc(20);
    chk("t6_no_pulse", 32'(pulses - p0), 32'd0);
    chk("t6_halted", 32'(halted), 32'd1);
    chk("t6_cnt_zero", 32'(u_dut.u_presc.cnt_q), 32'd0);

    // Exponent clamp.
    div_sel = 5'd31;
    wait_cyc(2);
    chk("clamp_mask", 32'(u_dut.u_presc.mask), 32'h00FF_FFFF);
    chk("clamp_sel", 32'(u_dut.u_presc.sel_q), 32'd24);

    // Randomised traffic against the model.
    div_sel = 5'd0;
    for (int i = 0; i < 3000; i++) begin
      run_req  = ($urandom_range(0, 19) == 0);
      halt_req = ($urandom_range(0, 24) == 0);
      step_req = ($urandom_range(0, 9) == 0);
      bp_hit   = ($urandom_range(0, 14) == 0);
      rst      = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 99) == 0) div_sel = 5'($urandom_range(0, 4));
      if ($urandom_range(0, 999) == 0) div_sel = 5'd31;
      wait_cyc(1);
    end
    run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0; bp_hit = 1'b0; rst = 1'b0;
    wait_cyc(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
